network_mul_arb: RTL and testbench

NETWORK_MUL_ARB -- requirements
Module: network_mul_arb

---
 rtl/network_mul_arb.sv | 116 +++++++++++
 tb/tb_network_mul_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/network_mul_arb.sv
// Two-requester signed multiplier with a round-robin arbiter in front of a
// two-stage pipeline. Stage 1 captures the granted operand pair; stage 2
// holds the full-precision 30-bit product. The whole pipeline stalls as a
// unit when a result is waiting and the consumer is not ready.
module network_mul_arb (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               req0_valid,
  input  logic signed [15:0] req0_a,
  input  logic signed [13:0] req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic signed [15:0] req1_a,
  input  logic signed [13:0] req1_b,
  output logic               req1_ready,
  output logic               res_valid,
  output logic               res_id,
  output logic signed [29:0] res_data,
  input  logic               res_ready,
  output logic               busy
);

  // Round-robin pointer: names the requester that wins when both are valid.
  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_t;

  prio_t prio;
  prio_t prio_next;

  logic ce;
  logic grant0;
  logic grant1;
  logic grant_any;

  logic               s1_valid;
  logic               s1_id;
  logic signed [15:0] s1_a;
  logic signed [13:0] s1_b;

  logic               s2_valid;
  logic               s2_id;
  logic signed [29:0] s2_data;

  logic signed [15:0] sel_a;
  logic signed [13:0] sel_b;
  logic signed [29:0] product;

  // Pipeline advances unless a result is held against a not-ready consumer.
  assign ce = !(s2_valid && !res_ready);

  // Arbitration: a lone valid requester wins; on contention prio decides.
  // Grants are suppressed during reset and stalls so no pair is lost.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    prio_next = prio;
    if (ap_rst_n && ce) begin
      if (req0_valid && (!req1_valid || prio == PRIO_REQ0)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    if (grant0) begin
      prio_next = PRIO_REQ1;
    end else if (grant1) begin
      prio_next = PRIO_REQ0;
    end
  end

  assign grant_any  = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_a = grant1 ? req1_a : req0_a;
  assign sel_b = grant1 ? req1_b : req0_b;

  // Both operands are sign-extended to the product width first, so the
  // low 30 bits of the multiply are the exact signed product.
  assign product = 30'(s1_a) * 30'(s1_b);

  // Control state: valids and the arbitration pointer are the only reset state.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      prio     <= PRIO_REQ0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      prio <= prio_next;
      if (ce) begin
        s1_valid <= grant_any;
        s2_valid <= s1_valid;
      end
    end
  end

  // Datapath registers follow the enable only; their contents are don't-care
  // whenever the matching valid is low, so they carry no reset.
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      s1_a    <= sel_a;
      s1_b    <= sel_b;
      s1_id   <= grant1;
      s2_data <= product;
      s2_id   <= s1_id;
    end
  end

  assign res_valid = s2_valid;
  assign res_id    = s2_id;
  assign res_data  = s2_data;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_network_mul_arb.sv
// Scoreboard bench for network_mul_arb: stimulus pushes the expected result
// of each accepted pair, a negedge monitor pops and compares every result
// the DUT hands over.
module tb_network_mul_arb;

  logic               ap_clk;
  logic               ap_rst_n;
  logic               req0_valid;
  logic signed [15:0] req0_a;
  logic signed [13:0] req0_b;
  logic               req0_ready;
  logic               req1_valid;
  logic signed [15:0] req1_a;
  logic signed [13:0] req1_b;
  logic               req1_ready;
  logic               res_valid;
  logic               res_id;
  logic signed [29:0] res_data;
  logic               res_ready;
  logic               busy;

  typedef struct packed {
    logic id;
    int   data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;

  network_mul_arb dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock cycle of stimulus: drive just after the rising edge, check the
  // ready outputs mid-cycle, and record the expected result of an acceptance.
  task automatic applyStimulus(input logic rst_n,
                               input logic v0, input int a0, input int b0,
                               input logic v1, input int a1, input int b1,
                               input logic rr,
                               input logic exp_r0, input logic exp_r1,
                               input int exp_data);
    exp_t e;
    @(posedge ap_clk);
    #1;
    ap_rst_n   = rst_n;
    req0_valid = v0;
    req0_a     = 16'(a0);
    req0_b     = 14'(b0);
    req1_valid = v1;
    req1_a     = 16'(a1);
    req1_b     = 14'(b1);
    res_ready  = rr;
    @(negedge ap_clk);
    checkOutput("req0_ready", int'(req0_ready), int'(exp_r0));
    checkOutput("req1_ready", int'(req1_ready), int'(exp_r1));
    if (rst_n && (exp_r0 || exp_r1)) begin
      e.id   = exp_r1;
      e.data = exp_data;
      exp_q.push_back(e);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 1, 1, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0, 0);
      if (i > 0) begin
        checkOutput("reset_res_valid", int'(res_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
      end
    end
  endtask

  // Monitor: every handed-over result must match the oldest expectation.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && res_valid && res_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result: got id=%0d data=%0d expected no result",
                 res_id, res_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("res_id", int'(res_id), int'(e.id));
        checkOutput("res_data", int'(res_data), e.data);
      end
    end
  end

  initial begin
    int a;
    int b;
    int pops_start;

    ap_rst_n   = 1'b0;
    req0_valid = 1'b0;
    req0_a     = '0;
    req0_b     = '0;
    req1_valid = 1'b0;
    req1_a     = '0;
    req1_b     = '0;
    res_ready  = 1'b0;

    $display("[TB] reset with both requesters asserting valid");
    resetCycles(3);
    idleCycle();

    $display("[TB] single request and latency");
    applyStimulus(1'b1, 1'b1, -3, 5, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, -15);
    checkOutput("lat_c0_busy", int'(busy), 0);
    idleCycle();
    checkOutput("lat_c1_res_valid", int'(res_valid), 0);
    checkOutput("lat_c1_busy", int'(busy), 1);
    idleCycle();
    checkOutput("lat_c2_res_valid", int'(res_valid), 1);
    checkOutput("lat_c2_res_data", int'(res_data), -15);
    idleCycle();
    checkOutput("lat_c3_res_valid", int'(res_valid), 0);
    checkOutput("lat_c3_busy", int'(busy), 0);

    $display("[TB] extreme operands");
    applyStimulus(1'b1, 1'b1, -32768, -8192, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 268435456);
    applyStimulus(1'b1, 1'b1, 32767, 8191, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 268394497);
    applyStimulus(1'b1, 1'b1, -32768, 8191, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, -268402688);
    for (int i = 0; i < 3; i++) idleCycle();

    $display("[TB] contention after reset");
    resetCycles(2);
    applyStimulus(1'b1, 1'b1, 7, -4, 1'b1, -100, 50, 1'b1, 1'b1, 1'b0, -28);
    applyStimulus(1'b1, 1'b1, 7, -4, 1'b1, -100, 50, 1'b1, 1'b0, 1'b1, -5000);
    applyStimulus(1'b1, 1'b1, 7, -4, 1'b1, -100, 50, 1'b1, 1'b1, 1'b0, -28);
    applyStimulus(1'b1, 1'b1, 7, -4, 1'b1, -100, 50, 1'b1, 1'b0, 1'b1, -5000);
    for (int i = 0; i < 3; i++) idleCycle();

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 3, 4, 1'b1, 1'b0, 1'b1, 12);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 5, 6, 1'b1, 1'b0, 1'b1, 30);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 8, 9, 1'b1, 11, 2, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("stall_res_valid", int'(res_valid), 1);
      checkOutput("stall_res_id", int'(res_id), 1);
      checkOutput("stall_res_data", int'(res_data), 12);
      checkOutput("stall_busy", int'(busy), 1);
    end
    applyStimulus(1'b1, 1'b1, 8, 9, 1'b1, 11, 2, 1'b1, 1'b1, 1'b0, 72);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 11, 2, 1'b1, 1'b0, 1'b1, 22);
    for (int i = 0; i < 4; i++) idleCycle();

    $display("[TB] reset with two pairs in flight");
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 3, 3, 1'b1, 1'b0, 1'b1, 9);
    applyStimulus(1'b1, 1'b1, 2, -5, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, -10);
    applyStimulus(1'b0, 1'b1, 5, 5, 1'b1, 6, 6, 1'b1, 1'b0, 1'b0, 0);
    exp_q.delete();
    applyStimulus(1'b1, 1'b1, -9, 9, 1'b1, 4, 4, 1'b1, 1'b1, 1'b0, -81);
    checkOutput("post_reset_res_valid", int'(res_valid), 0);
    checkOutput("post_reset_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) idleCycle();

    $display("[TB] back-to-back throughput on requester 1");
    pops_start = pops;
    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(65535)) - 32768;
      b = int'($urandom_range(16383)) - 8192;
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, a, b, 1'b1, 1'b0, 1'b1, a * b);
    end
    idleCycle();
    idleCycle();
    #1;
    checkOutput("throughput_results", pops - pops_start, 16);
    for (int i = 0; i < 3; i++) idleCycle();

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
